// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: stall hold, flush bubbles, valid bit, saturating bubble counter.
// Optional load-use hazard detection with self-inserted bubbles when ID_EX_LOAD_USE_DETECT_EN is defined.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk_in,
  input  logic              Reset_in,
  input  logic              Stall_in,
  input  logic              Flush_in,
  input  logic              Valid_ID,
  input  logic [4:0]        rs_ID,
  input  logic              RegWrite_ID,
  input  logic              MemtoReg_ID,
  input  logic              Branch_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic              RegDst_ID,
  input  logic [5:0]        ALUOp_ID,
  input  logic              ALUSrc_ID,
  input  logic              JR_ID,
  input  logic              j_and_jal_ID,
  input  logic              special_rt_ID,
  input  logic [1:0]        size_ID,
  input  logic [DATA_W-1:0] PCAddResult_ID,
  input  logic [DATA_W-1:0] ReadData1_ID,
  input  logic [DATA_W-1:0] ReadData2_ID,
  input  logic [DATA_W-1:0] SignExtResult_ID,
  input  logic [4:0]        rt_ID,
  input  logic [4:0]        rd_ID,
  output logic              RegWrite_EX,
  output logic              MemtoReg_EX,
  output logic              Branch_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              RegDst_EX,
  output logic [5:0]        ALUOp_EX,
  output logic              ALUSrc_EX,
  output logic              JR_EX,
  output logic              j_and_jal_EX,
  output logic              special_rt_EX,
  output logic [1:0]        size_EX,
  output logic [DATA_W-1:0] PCAddResult_EX,
  output logic [DATA_W-1:0] ReadData1_EX,
  output logic [DATA_W-1:0] ReadData2_EX,
  output logic [DATA_W-1:0] SignExtResult_EX,
  output logic [4:0]        rt_EX,
  output logic [4:0]        rd_EX,
  output logic              Valid_EX,
  output logic [CNT_W-1:0]  Bubble_Count,
  output logic              Hazard_Stall_out
);

  logic w_hazard;
  logic w_internal_bubble;
  logic w_bubble;

`ifdef ID_EX_LOAD_USE_DETECT_EN
  // Load in EX whose destination feeds the instruction in ID, checked regardless of Valid_ID.
  assign w_hazard = Valid_EX & MemRead_EX & (rt_EX != 5'd0) &
                    ((rt_EX == rs_ID) | (rt_EX == rt_ID));
  assign w_internal_bubble = w_hazard & ~Stall_in;
`else
  logic w_unused_rs;
  assign w_unused_rs       = ^rs_ID;
  assign w_hazard          = 1'b0;
  assign w_internal_bubble = 1'b0;
`endif

  assign Hazard_Stall_out = w_hazard;
  assign w_bubble         = Flush_in | w_internal_bubble;

  // Priority: reset > bubble > stall > load.
  always_ff @(posedge Clk_in) begin
    if (Reset_in || w_bubble) begin
      RegWrite_EX      <= 1'b0;
      MemtoReg_EX      <= 1'b0;
      Branch_EX        <= 1'b0;
      MemRead_EX       <= 1'b0;
      MemWrite_EX      <= 1'b0;
      RegDst_EX        <= 1'b0;
      ALUOp_EX         <= 6'd0;
      ALUSrc_EX        <= 1'b0;
      JR_EX            <= 1'b0;
      j_and_jal_EX     <= 1'b0;
      special_rt_EX    <= 1'b0;
      size_EX          <= 2'd0;
      PCAddResult_EX   <= '0;
      ReadData1_EX     <= '0;
      ReadData2_EX     <= '0;
      SignExtResult_EX <= '0;
      rt_EX            <= 5'd0;
      rd_EX            <= 5'd0;
      Valid_EX         <= 1'b0;
      if (Reset_in) begin
        Bubble_Count <= '0;
      end else if (Bubble_Count != {CNT_W{1'b1}}) begin
        Bubble_Count <= Bubble_Count + CNT_W'(1);
      end
    end else if (!Stall_in) begin
      RegWrite_EX      <= RegWrite_ID;
      MemtoReg_EX      <= MemtoReg_ID;
      Branch_EX        <= Branch_ID;
      MemRead_EX       <= MemRead_ID;
      MemWrite_EX      <= MemWrite_ID;
      RegDst_EX        <= RegDst_ID;
      ALUOp_EX         <= ALUOp_ID;
      ALUSrc_EX        <= ALUSrc_ID;
      JR_EX            <= JR_ID;
      j_and_jal_EX     <= j_and_jal_ID;
      special_rt_EX    <= special_rt_ID;
      size_EX          <= size_ID;
      PCAddResult_EX   <= PCAddResult_ID;
      ReadData1_EX     <= ReadData1_ID;
      ReadData2_EX     <= ReadData2_ID;
      SignExtResult_EX <= SignExtResult_ID;
      rt_EX            <= rt_ID;
      rd_EX            <= rd_ID;
      Valid_EX         <= Valid_ID;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (CNT_W=4 build to reach counter saturation).
// Expectations follow ID_EX_LOAD_USE_DETECT_EN when it is defined.
module tb_id_ex_pipe_reg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUS_W  = 156;

  logic clk = 1'b0;
  logic Reset_in, Stall_in, Flush_in, Valid_ID;
  logic [4:0] rs_ID, rt_ID, rd_ID;
  logic RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID;
  logic [5:0] ALUOp_ID;
  logic ALUSrc_ID, JR_ID, j_and_jal_ID, special_rt_ID;
  logic [1:0] size_ID;
  logic [DATA_W-1:0] PCAddResult_ID, ReadData1_ID, ReadData2_ID, SignExtResult_ID;

  logic RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, RegDst_EX;
  logic [5:0] ALUOp_EX;
  logic ALUSrc_EX, JR_EX, j_and_jal_EX, special_rt_EX;
  logic [1:0] size_EX;
  logic [DATA_W-1:0] PCAddResult_EX, ReadData1_EX, ReadData2_EX, SignExtResult_EX;
  logic [4:0] rt_EX, rd_EX;
  logic Valid_EX, Hazard_Stall_out;
  logic [CNT_W-1:0] Bubble_Count;

  int total = 0;
  int bad   = 0;
  logic [BUS_W-1:0] exp_bus;
  logic [BUS_W-1:0] w_id_bus;
  logic [BUS_W-1:0] w_ex_bus;
`ifdef ID_EX_LOAD_USE_DETECT_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  assign w_id_bus = {RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID,
                     ALUOp_ID, ALUSrc_ID, JR_ID, j_and_jal_ID, special_rt_ID, size_ID,
                     PCAddResult_ID, ReadData1_ID, ReadData2_ID, SignExtResult_ID, rt_ID, rd_ID};
  assign w_ex_bus = {RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, RegDst_EX,
                     ALUOp_EX, ALUSrc_EX, JR_EX, j_and_jal_EX, special_rt_EX, size_EX,
                     PCAddResult_EX, ReadData1_EX, ReadData2_EX, SignExtResult_EX, rt_EX, rd_EX};

  id_ex_pipe_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .Clk_in(clk), .Reset_in(Reset_in), .Stall_in(Stall_in), .Flush_in(Flush_in),
    .Valid_ID(Valid_ID), .rs_ID(rs_ID),
    .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .Branch_ID(Branch_ID),
    .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegDst_ID(RegDst_ID),
    .ALUOp_ID(ALUOp_ID), .ALUSrc_ID(ALUSrc_ID), .JR_ID(JR_ID), .j_and_jal_ID(j_and_jal_ID),
    .special_rt_ID(special_rt_ID), .size_ID(size_ID), .PCAddResult_ID(PCAddResult_ID),
    .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
    .SignExtResult_ID(SignExtResult_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .Branch_EX(Branch_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .RegDst_EX(RegDst_EX),
    .ALUOp_EX(ALUOp_EX), .ALUSrc_EX(ALUSrc_EX), .JR_EX(JR_EX), .j_and_jal_EX(j_and_jal_EX),
    .special_rt_EX(special_rt_EX), .size_EX(size_EX), .PCAddResult_EX(PCAddResult_EX),
    .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
    .SignExtResult_EX(SignExtResult_EX), .rt_EX(rt_EX), .rd_EX(rd_EX),
    .Valid_EX(Valid_EX), .Bubble_Count(Bubble_Count), .Hazard_Stall_out(Hazard_Stall_out)
  );

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_id();
    {RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID} = '0;
    {ALUOp_ID, ALUSrc_ID, JR_ID, j_and_jal_ID, special_rt_ID, size_ID} = '0;
    {PCAddResult_ID, ReadData1_ID, ReadData2_ID, SignExtResult_ID} = '0;
    {rs_ID, rt_ID, rd_ID, Valid_ID} = '0;
  endtask

  // Random bundle with MemRead_ID cleared so no load-use hazard is created by accident.
  task automatic rand_id();
    {RegWrite_ID, MemtoReg_ID, Branch_ID, MemWrite_ID, RegDst_ID} = 5'($urandom);
    MemRead_ID = 1'b0;
    ALUOp_ID = 6'($urandom);
    {ALUSrc_ID, JR_ID, j_and_jal_ID, special_rt_ID, size_ID} = 6'($urandom);
    PCAddResult_ID = $urandom; ReadData1_ID = $urandom;
    ReadData2_ID = $urandom;   SignExtResult_ID = $urandom;
    rs_ID = 5'($urandom); rt_ID = 5'($urandom); rd_ID = 5'($urandom);
    Valid_ID = 1'b1;
  endtask

  initial begin
    Reset_in = 1'b1; Stall_in = 1'b0; Flush_in = 1'b0;
    rand_id();
    MemRead_ID = 1'b1;
    tick(); rand_id(); tick();
    chk("reset_bus", BUS_W'(w_ex_bus), BUS_W'(0));
    chk("reset_valid", BUS_W'(Valid_EX), BUS_W'(0));
    chk("reset_count", BUS_W'(Bubble_Count), BUS_W'(0));
    chk("reset_hazard", BUS_W'(Hazard_Stall_out), BUS_W'(0));

    // Load path with one-edge latency
    Reset_in = 1'b0; zero_id();
    ALUOp_ID = 6'h21; ReadData1_ID = 32'hDEADBEEF; rt_ID = 5'd9; Valid_ID = 1'b1;
    #1;
    chk("load_before_edge", BUS_W'(ALUOp_EX), BUS_W'(0));
    tick();
    chk("load_aluop", BUS_W'(ALUOp_EX), BUS_W'(6'h21));
    chk("load_rd1", BUS_W'(ReadData1_EX), BUS_W'(32'hDEADBEEF));
    chk("load_rt", BUS_W'(rt_EX), BUS_W'(9));
    chk("load_valid", BUS_W'(Valid_EX), BUS_W'(1));

    rand_id(); #1; exp_bus = w_id_bus;
    tick();
    chk("load_full_bus", w_ex_bus, exp_bus);

    // Stall holds everything
    zero_id(); PCAddResult_ID = 32'h104; Valid_ID = 1'b1;
    tick();
    chk("stall_pre", BUS_W'(PCAddResult_EX), BUS_W'(32'h104));
    Stall_in = 1'b1; PCAddResult_ID = 32'h200; Valid_ID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold_%0d", i), BUS_W'(PCAddResult_EX), BUS_W'(32'h104));
    end
    chk("stall_valid_hold", BUS_W'(Valid_EX), BUS_W'(1));
    chk("stall_count_hold", BUS_W'(Bubble_Count), BUS_W'(0));
    Stall_in = 1'b0; Valid_ID = 1'b1;
    tick();
    chk("stall_release", BUS_W'(PCAddResult_EX), BUS_W'(32'h200));

    // Flush beats stall
    RegWrite_ID = 1'b1; MemWrite_ID = 1'b1; ReadData1_ID = 32'h1234_5678;
    Flush_in = 1'b1; Stall_in = 1'b1;
    tick();
    chk("flush_regwrite", BUS_W'(RegWrite_EX), BUS_W'(0));
    chk("flush_memwrite", BUS_W'(MemWrite_EX), BUS_W'(0));
    chk("flush_bus", w_ex_bus, BUS_W'(0));
    chk("flush_valid", BUS_W'(Valid_EX), BUS_W'(0));
    chk("flush_count1", BUS_W'(Bubble_Count), BUS_W'(1));
    Stall_in = 1'b0; Valid_ID = 1'b0;
    tick();
    chk("flush_invalid_counts", BUS_W'(Bubble_Count), BUS_W'(2));

    // Saturation after 2^CNT_W forced bubbles from reset
    Flush_in = 1'b0; Reset_in = 1'b1; tick(); Reset_in = 1'b0;
    Flush_in = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("count_14", BUS_W'(Bubble_Count), BUS_W'(4'hE));
    tick(); tick();
    chk("count_sat", BUS_W'(Bubble_Count), BUS_W'(4'hF));
    tick();
    chk("count_sat_hold", BUS_W'(Bubble_Count), BUS_W'(4'hF));
    Flush_in = 1'b0;

    // Reset mid-stall wins, next edge loads
    rand_id(); tick();
    Stall_in = 1'b1; Reset_in = 1'b1;
    tick();
    chk("reset_in_stall_bus", w_ex_bus, BUS_W'(0));
    chk("reset_in_stall_count", BUS_W'(Bubble_Count), BUS_W'(0));
    Stall_in = 1'b0; Reset_in = 1'b0;
    rand_id(); #1; exp_bus = w_id_bus;
    tick();
    chk("post_reset_load", w_ex_bus, exp_bus);
    chk("post_reset_valid", BUS_W'(Valid_EX), BUS_W'(1));

    // Load-use: lw with rt=8 in EX, consumer with rs=8 in ID
    Reset_in = 1'b1; tick(); Reset_in = 1'b0;
    zero_id(); MemRead_ID = 1'b1; rt_ID = 5'd8; Valid_ID = 1'b1; MemtoReg_ID = 1'b1;
    tick();
    zero_id(); rs_ID = 5'd8; rt_ID = 5'd3; RegWrite_ID = 1'b1; Valid_ID = 1'b1;
    #1;
    chk("lu_hazard", BUS_W'(Hazard_Stall_out), BUS_W'(LU_EN));
    tick();
    chk("lu_valid_ex", BUS_W'(Valid_EX), BUS_W'(!LU_EN));
    chk("lu_count", BUS_W'(Bubble_Count), BUS_W'(LU_EN));
    chk("lu_hazard_clear", BUS_W'(Hazard_Stall_out), BUS_W'(0));

    // Load to $zero never hazards
    zero_id(); MemRead_ID = 1'b1; rt_ID = 5'd0; Valid_ID = 1'b1;
    tick();
    zero_id(); rs_ID = 5'd0; rt_ID = 5'd0; Valid_ID = 1'b1;
    #1;
    chk("lu_r0_hazard", BUS_W'(Hazard_Stall_out), BUS_W'(0));
    tick();
    chk("lu_r0_valid", BUS_W'(Valid_EX), BUS_W'(1));
    chk("lu_r0_count", BUS_W'(Bubble_Count), BUS_W'(LU_EN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
